// File: rtl/corral_pkg.sv
// Shared state encoding, default parameters and the saturating position helper
// used by the Corral game engine.
package corral_pkg;

    typedef enum logic [2:0] {
        SETUP   = 3'd0,
        IDLE    = 3'd1,
        RESOLVE = 3'd2,
        KICK    = 3'd3,
        DONE    = 3'd4
    } state_t;

    localparam int         DEF_POS_W       = 4;
    localparam int         DEF_MOVE_W      = 3;
    localparam int         DEF_MAX_MOVE    = 5;
    localparam int         DEF_HORSE_START = 10;
    localparam int         DEF_BASE_HP     = 2;
    localparam int         DEF_BOLT_BASE   = 5;
    localparam int         DEF_MAX_ROUNDS  = 8;
    localparam int         DEF_LFSR_W      = 8;
    localparam logic [7:0] DEF_LFSR_SEED   = 8'h5A;
    localparam logic [7:0] DEF_LFSR_TAPS   = 8'hB8;

    // Saturate a signed intermediate position into the range 0..amax.
    function automatic logic [15:0] clamp_pos(input logic signed [15:0] v,
                                              input logic signed [15:0] amax);
        logic [15:0] r;
        if (v < 16'sd0) begin
            r = 16'd0;
        end else if (v > amax) begin
            r = amax;
        end else begin
            r = v;
        end
        return r;
    endfunction

endpackage

// File: rtl/corral_lfsr.sv
// Free-running Galois LFSR; exposes its two low bits as the engine's random value.
module corral_lfsr #(
    parameter int                LFSR_W    = 8,
    parameter logic [LFSR_W-1:0] LFSR_SEED = 8'h5A,
    parameter logic [LFSR_W-1:0] LFSR_TAPS = 8'hB8
) (
    input  logic       clock,
    input  logic       reset_n,
    output logic [1:0] rnd_o
);

    logic [LFSR_W-1:0] lfsr_q;

    // Shift right and fold the tap mask in whenever a one falls out of the LSB.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            lfsr_q <= LFSR_SEED;
        end else if (lfsr_q[0]) begin
            lfsr_q <= {1'b0, lfsr_q[LFSR_W-1:1]} ^ LFSR_TAPS;
        end else begin
            lfsr_q <= {1'b0, lfsr_q[LFSR_W-1:1]};
        end
    end

    assign rnd_o = lfsr_q[1:0];

endmodule

// File: rtl/corral_game_p.sv
// Corral game engine: cowboy chases a horse on a 1-D arena, moves arrive over
// valid/ready, horse responses (drift, bolt, kick) are driven by a random value.
module corral_game_p
    import corral_pkg::*;
#(
    parameter int                POS_W       = DEF_POS_W,
    parameter int                MOVE_W      = DEF_MOVE_W,
    parameter int                MAX_MOVE    = DEF_MAX_MOVE,
    parameter int                HORSE_START = DEF_HORSE_START,
    parameter int                BASE_HP     = DEF_BASE_HP,
    parameter int                BOLT_BASE   = DEF_BOLT_BASE,
    parameter int                MAX_ROUNDS  = DEF_MAX_ROUNDS,
    parameter int                LFSR_W      = DEF_LFSR_W,
    parameter logic [LFSR_W-1:0] LFSR_SEED   = DEF_LFSR_SEED,
    localparam int               RC_W        = $clog2(MAX_ROUNDS + 1)
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              move_valid,
    input  logic [MOVE_W-1:0] move,
    output logic              move_ready,
    output logic              move_err,
    input  logic              new_game,
    input  logic              rnd_force,
    input  logic [1:0]        rnd_val,
    output logic [POS_W-1:0]  cowboy_pos,
    output logic [POS_W-1:0]  horse_pos,
    output logic [RC_W-1:0]   round_cnt,
    output logic [2:0]        kicks_left,
    output logic              game_over,
    output logic              won
);

    localparam int                     IW     = POS_W + 2;
    localparam int                     AMAX   = (1 << POS_W) - 1;
    localparam logic signed [IW-1:0]   AMAX_S = IW'(AMAX);
    localparam logic signed [IW-1:0]   ONE_S  = IW'(1);

    function automatic logic [POS_W-1:0] sat(input logic signed [IW-1:0] v);
        logic [15:0] r;
        r = clamp_pos(16'(v), 16'(AMAX_S));
        return POS_W'(r);
    endfunction

    state_t              state_q;
    logic [POS_W-1:0]    cowboy_q;
    logic [POS_W-1:0]    horse_q;
    logic [RC_W-1:0]     round_q;
    logic [3:0]          hp_q;
    logic [3:0]          kicks_q;
    logic [2:0]          kicks_left_q;
    logic [MOVE_W-1:0]   move_q;
    logic [2:0]          kick_timer_q;
    logic                game_over_q;
    logic                won_q;
    logic                move_ready_q;
    logic                move_err_q;

    logic [1:0]          lfsr_rnd_s;
    logic [1:0]          pval_s;
    logic signed [IW-1:0] cow_s;
    logic signed [IW-1:0] horse_s;
    logic signed [IW-1:0] step_s;
    logic signed [IW-1:0] dest_s;
    logic signed [IW-1:0] amt_s;
    logic [IW-1:0]       dist_s;
    logic [IW-1:0]       twice_s;
    logic                toward_s;
    logic                away_up_s;
    logic                move_legal_s;
    logic                timeout_s;
    logic [POS_W-1:0]    horse_res_s;
    logic [POS_W-1:0]    horse_kick_s;
    logic [POS_W-1:0]    cow_kick_s;
    logic [POS_W-1:0]    horse_setup_s;
    logic [3:0]          hp_setup_s;
    logic [3:0]          kicks_inc_s;
    logic [2:0]          kicks_left_inc_s;

    corral_lfsr #(
        .LFSR_W    (LFSR_W),
        .LFSR_SEED (LFSR_SEED),
        .LFSR_TAPS (LFSR_W'(DEF_LFSR_TAPS))
    ) u_lfsr (
        .clock   (clock),
        .reset_n (reset_n),
        .rnd_o   (lfsr_rnd_s)
    );

    // Move legality, distances and candidate positions, all in signed POS_W+2 bits.
    always_comb begin
        pval_s       = rnd_force ? rnd_val : lfsr_rnd_s;
        cow_s        = $signed(IW'(cowboy_q));
        horse_s      = $signed(IW'(horse_q));
        step_s       = $signed(IW'(move));
        toward_s     = (cowboy_q <= horse_q);
        away_up_s    = (horse_q >= cowboy_q);
        dest_s       = toward_s ? (cow_s + step_s) : (cow_s - step_s);
        move_legal_s = (move != {MOVE_W{1'b0}}) && (32'(move) <= MAX_MOVE)
                       && !dest_s[IW-1] && (dest_s <= AMAX_S);
        dist_s       = (cowboy_q >= horse_q) ? IW'(cowboy_q - horse_q)
                                             : IW'(horse_q - cowboy_q);
        twice_s      = IW'({move_q, 1'b0});
        if (dist_s < twice_s) begin
            amt_s = $signed(IW'(BOLT_BASE)) + $signed(IW'({pval_s, 1'b0}));
        end else begin
            amt_s = $signed(IW'(pval_s));
        end
        horse_res_s      = sat(away_up_s ? (horse_s + amt_s) : (horse_s - amt_s));
        horse_kick_s     = sat(away_up_s ? (horse_s + ONE_S) : (horse_s - ONE_S));
        cow_kick_s       = sat(toward_s ? (cow_s - ONE_S) : (cow_s + ONE_S));
        horse_setup_s    = sat($signed(IW'(HORSE_START)) + $signed(IW'(pval_s)));
        hp_setup_s       = 4'(BASE_HP) + 4'(pval_s);
        kicks_inc_s      = kicks_q + 4'd1;
        kicks_left_inc_s = (hp_q > kicks_inc_s) ? 3'(hp_q - kicks_inc_s) : 3'd0;
        timeout_s        = (round_q == RC_W'(MAX_ROUNDS));
    end

    // Game FSM with all outputs held in registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= SETUP;
            cowboy_q     <= {POS_W{1'b0}};
            horse_q      <= {POS_W{1'b0}};
            round_q      <= {RC_W{1'b0}};
            hp_q         <= 4'd0;
            kicks_q      <= 4'd0;
            kicks_left_q <= 3'd0;
            move_q       <= {MOVE_W{1'b0}};
            kick_timer_q <= 3'd0;
            game_over_q  <= 1'b0;
            won_q        <= 1'b0;
            move_ready_q <= 1'b0;
            move_err_q   <= 1'b0;
        end else begin
            move_err_q <= 1'b0;
            case (state_q)
                SETUP: begin
                    cowboy_q     <= {POS_W{1'b0}};
                    horse_q      <= horse_setup_s;
                    hp_q         <= hp_setup_s;
                    kicks_q      <= 4'd0;
                    kicks_left_q <= 3'(hp_setup_s);
                    round_q      <= {RC_W{1'b0}};
                    game_over_q  <= 1'b0;
                    won_q        <= 1'b0;
                    move_ready_q <= 1'b1;
                    state_q      <= IDLE;
                end
                IDLE: begin
                    if (move_valid && move_ready_q) begin
                        if (move_legal_s) begin
                            cowboy_q     <= dest_s[POS_W-1:0];
                            round_q      <= round_q + RC_W'(1);
                            move_q       <= move;
                            move_ready_q <= 1'b0;
                            state_q      <= RESOLVE;
                        end else begin
                            move_err_q <= 1'b1;
                        end
                    end else begin
                        state_q <= IDLE;
                    end
                end
                RESOLVE: begin
                    if ((dist_s == IW'(0)) || ((dist_s == IW'(1)) && (pval_s >= 2'd2))) begin
                        won_q       <= 1'b1;
                        game_over_q <= 1'b1;
                        state_q     <= DONE;
                    end else if (dist_s == IW'(1)) begin
                        kicks_q      <= kicks_inc_s;
                        kicks_left_q <= kicks_left_inc_s;
                        if (kicks_inc_s > hp_q) begin
                            won_q       <= 1'b0;
                            game_over_q <= 1'b1;
                            state_q     <= DONE;
                        end else begin
                            kick_timer_q <= 3'(pval_s) + 3'd2;
                            state_q      <= KICK;
                        end
                    end else begin
                        horse_q <= horse_res_s;
                        if (timeout_s) begin
                            won_q       <= 1'b0;
                            game_over_q <= 1'b1;
                            state_q     <= DONE;
                        end else begin
                            move_ready_q <= 1'b1;
                            state_q      <= IDLE;
                        end
                    end
                end
                KICK: begin
                    horse_q      <= horse_kick_s;
                    cowboy_q     <= cow_kick_s;
                    kick_timer_q <= kick_timer_q - 3'd1;
                    if (kick_timer_q <= 3'd1) begin
                        if (timeout_s) begin
                            won_q       <= 1'b0;
                            game_over_q <= 1'b1;
                            state_q     <= DONE;
                        end else begin
                            move_ready_q <= 1'b1;
                            state_q      <= IDLE;
                        end
                    end else begin
                        state_q <= KICK;
                    end
                end
                DONE: begin
                    if (new_game) begin
                        state_q <= SETUP;
                    end else begin
                        state_q <= DONE;
                    end
                end
                default: begin
                    move_ready_q <= 1'b0;
                    state_q      <= SETUP;
                end
            endcase
        end
    end

    assign move_ready = move_ready_q;
    assign move_err   = move_err_q;
    assign cowboy_pos = cowboy_q;
    assign horse_pos  = horse_q;
    assign round_cnt  = round_q;
    assign kicks_left = kicks_left_q;
    assign game_over  = game_over_q;
    assign won        = won_q;

endmodule
